// File: rtl/tdm_demux_eight.sv
// Receive side of the TDM path: steers serial samples into NCH slots and
// publishes each completed frame on a parallel bus with a one-cycle strobe.

module tdm_demux_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module tdm_demux_eight #(
  parameter int WIDTH = 1,
  parameter int NCH   = 8,
  parameter int SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sync,
  input  logic [WIDTH-1:0]     din,
  output logic [SEL_W-1:0]     slot,
  output logic [NCH*WIDTH-1:0] ch_out,
  output logic                 frame_valid,
  output logic                 sync_err
);
  logic [NCH-1:0][WIDTH-1:0] shadow;
  logic [NCH-1:0][WIDTH-1:0] frame_next;
  logic [SEL_W-1:0]          wr_slot;
  logic                      last, resync;

  assign last    = (slot == SEL_W'(NCH-1));
  // A misaligned sync restarts the frame: the sample lands in slot 0.
  assign resync  = in_valid && in_sync && (slot != '0);
  assign wr_slot = resync ? '0 : slot;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    tdm_demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (in_valid && (wr_slot == SEL_W'(k))),
      .d   (din),
      .q   (shadow[k])
    );
    // Final slot bypasses the shadow so the frame publishes on its last edge.
    if (k == NCH-1) begin : g_last
      assign frame_next[k] = din;
    end else begin : g_mid
      assign frame_next[k] = shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot        <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
        if (resync) begin
          slot     <= SEL_W'(1);
          sync_err <= 1'b1;
        end else if (last) begin
          slot        <= '0;
          ch_out      <= frame_next;
          frame_valid <= 1'b1;
        end else begin
          slot <= slot + SEL_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_eight.sv
// Scoreboard bench for tdm_demux_eight: queue-based frame model, directed and random stimulus.

module tb_tdm_demux_eight;
  localparam int NCH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_sync = 1'b0;
  logic [0:0] din = '0;
  logic [2:0] slot;
  logic [7:0] ch_out;
  logic       frame_valid, sync_err;

  int errors = 0, checks = 0;

  // reference model: samples of the frame in progress, published frames, errors
  bit         cur[$];
  logic [7:0] exp_f[$];
  bit         exp_e[$];
  int         m_slot = 0;
  logic [7:0] m_ch = '0;

  tdm_demux_eight dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .din(din),
    .slot(slot), .ch_out(ch_out), .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit s, input bit d, input bit r = 1'b0);
    logic [7:0] f;
    @(negedge clk);
    rst = r; in_valid = v; in_sync = s; din = d;
    @(posedge clk);
    if (r) begin
      cur.delete(); m_ch = '0;
    end else if (v) begin
      if (s && cur.size() != 0) begin
        exp_e.push_back(1'b1);
        cur.delete();
      end
      cur.push_back(d);
      if (cur.size() == NCH) begin
        f = '0;
        for (int k = 0; k < NCH; k++) f[k] = cur[k];
        m_ch = f;
        exp_f.push_back(f);
        cur.delete();
      end
    end
    m_slot = cur.size();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    for (int k = 0; k < NCH; k++) begin
      step(1'b1, 1'b0, b[k]);
      if (gaps) step(1'b0, 1'b1, ~b[k]);
    end
  endtask

  // monitor: compares every cycle against the model, pops scoreboard on strobes
  initial begin
    forever begin
      @(posedge clk); #1;
      check("slot", slot, m_slot);
      check("ch_out", ch_out, m_ch);
      check("frame_valid", frame_valid, exp_f.size() != 0);
      if (frame_valid && exp_f.size() != 0) check("frame_data", ch_out, exp_f.pop_front());
      else if (exp_f.size() != 0) void'(exp_f.pop_front());
      check("sync_err", sync_err, exp_e.size() != 0);
      if (exp_e.size() != 0) void'(exp_e.pop_front());
      check("excl", frame_valid & sync_err, 1'b0);
    end
  end

  initial begin
    // reset
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    check("rst_slot", slot, 0);
    check("rst_ch_out", ch_out, 0);
    check("rst_strobes", {frame_valid, sync_err}, 0);

    // basic frame
    send_byte(8'b0100_1101, 1'b0);
    #2; check("t2_ch_out", ch_out, 8'h4D); check("t2_slot", slot, 0);
    step(1'b0, 1'b0, 1'b0);
    #2; check("t2_strobe_one_cycle", frame_valid, 1'b0);

    // gaps between accepts, sync ignored when invalid
    send_byte(8'hB2, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    send_byte(8'b0100_1101, 1'b1);
    #2; check("t3_ch_out", ch_out, 8'h4D);

    // misaligned sync
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    #2; check("t4_sync_err", sync_err, 1'b1); check("t4_slot", slot, 1);
    check("t4_hold", ch_out, 8'h4D);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    #2; check("t4_ch_out", ch_out, 8'h01); check("t4_fv", frame_valid, 1'b1);

    // aligned sync at slot 0 is a plain accept
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    #2; check("t4b_ch_out", ch_out, 8'h01);

    // back-to-back frames
    send_byte(8'hA5, 1'b0);
    #2; check("t5_a5", ch_out, 8'hA5);
    send_byte(8'h3C, 1'b0);
    #2; check("t5_3c", ch_out, 8'h3C);

    // reset mid-frame
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #2; check("t6_ch_out", ch_out, 8'h00); check("t6_slot", slot, 0);
    send_byte(8'h96, 1'b0);
    #2; check("t6_frame", ch_out, 8'h96);

    // random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 1'($urandom),
           $urandom_range(0, 199) == 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    check("sb_empty", exp_f.size() + exp_e.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
